fp_mult_sched: RTL and testbench
================================

// Module: fp_mult_sched
// PURPOSE
//  Round-robin scheduler sharing one fp_mult instance among NREQ requesters.
//  Latches the granted operands and restarts fp_mult for each operation by holding
//  its reset high. Waits for done, then returns result, flow flags and requester id
//  over a valid/ready response port. Sits between client engines and the single multiplier.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  TIMEOUT  127  max RUN cycles without m_done before the op is aborted
// PORTS
//  clk        in   1        clock, single domain
//  reset      in   1        synchronous, active-high
//  req        in   NREQ     per-requester request; hold with operands until gnt
//  a_in       in   32*NREQ  operand A, requester i at [32i+31:32i]
//  b_in       in   32*NREQ  operand B, same packing
//  gnt        out  NREQ     one-hot, 1-cycle pulse: operands consumed
//  rsp_valid  out  1        response valid; held until rsp_ready
//  rsp_ready  in   1        response accept
//  rsp_id     out  clog2(NREQ)  index of the served requester
//  rsp_c      out  32       product (IEEE single)
//  rsp_flow   out  2        {underflow, overflow}
//  rsp_err    out  1        timeout abort; rsp_c=0, rsp_flow=0
//  m_a, m_b   out  32       operands to fp_mult, stable from latch until return to IDLE
//  m_reset    out  1        fp_mult reset; high in every state except RUN
//  m_c        in   32       fp_mult C
//  m_done     in   1        fp_mult done
//  m_flow     in   1        fp_mult flow (overflow only)
// BEHAVIOUR
//  Reset values: gnt=0, rsp_valid=0, rsp_err=0, rsp_c=0, rsp_flow=0, rsp_id=0,
//   m_a=m_b=0, m_reset=1, rr pointer=NREQ-1 so index 0 wins first. FSM->IDLE.
//  FSM states: IDLE -> LAUNCH -> RUN -> RSP -> IDLE.
//  IDLE: if |req, pick the first set bit at or after ptr+1 (mod NREQ).
//   At the edge: latch m_a/m_b, rsp_id and gnt<=onehot; ptr<=winner.
//   Also latch uflow = ({1'b0,Aexp}+{1'b0,Bexp}) < 127. Then go to LAUNCH.
//  LAUNCH (1 cycle): gnt high, m_reset high. This gives fp_mult >=1 reset cycle with
//   stable operands. Clear the cycle counter; go to RUN.
//  RUN: m_reset=0. Counter increments each cycle.
//   If m_done: rsp_c<=m_c, rsp_flow<={uflow, m_flow&~uflow}, rsp_err<=0, rsp_valid<=1; go to RSP.
//   Else if counter==TIMEOUT: rsp_c<=0, rsp_flow<=0, rsp_err<=1, rsp_valid<=1; go to RSP.
//   m_done takes priority over timeout in the same cycle.
//  RSP: m_reset=1. All rsp_* held stable while rsp_valid&&!rsp_ready.
//   On accept: rsp_valid<=0; go to IDLE. The next grant is at the earliest in the IDLE cycle after.
//  req is sampled only in IDLE. req seen during LAUNCH/RUN/RSP is ignored, never lost.
//   A requester still holding req after its gnt is simply re-arbitrated.
//  Op latency: gnt at T+1 (req seen at T); m_reset low from T+2; response = fp_mult latency + 3.
//  Counter width = clog2(TIMEOUT+1); it never wraps, because the FSM exits at TIMEOUT.
//  Reset mid-operation: in-flight op is discarded with no response. m_reset goes high
//   on the next cycle. ptr returns to its reset value.
//  rsp_id is stable from LAUNCH through RSP.
// STRUCTURE
//  Shared package: state encoding (IDLE/LAUNCH/RUN/RSP), FP_BIAS=127, FP_EXP_MSB/LSB=30/23,
//   flow bit positions FLOW_OVF=0, FLOW_UNF=1.
//  Sub-module rr_arbiter #(NREQ): req, ptr -> one-hot grant plus encoded index, purely combinational.
//  This module holds the FSM, operand/result registers, counter and fp_mult port wiring.
//  fp_mult is instantiated by the parent, not inside this block.
// TESTING (bench pairs this block with a real fp_mult; NREQ=4)
//  1 req0: A=0x40000000 (2.0), B=0x40400000 (3.0) -> gnt=0001 one cycle;
//    rsp_c=0x40C00000, rsp_id=0, rsp_flow=00, rsp_err=0.
//  2 req=1111 held after reset, each dropped on its gnt -> gnt order 0,1,2,3.
//    Then req=1001 -> grant 0 before 3. Each rsp_id matches its gnt.
//  3 A=B=0x00800000 (exps 1+1<127) -> rsp_flow=10, rsp_c=0x00000000.
//    A=B=0x7F000000 -> rsp_flow=01, rsp_c=0x00000000.
//  4 rsp_ready low 10 cycles with req1 pending -> rsp_* stable, no gnt.
//    Ready high -> accept, then gnt=0010 follows.
//  5 m_done forced 0 (stub) -> rsp_valid after exactly TIMEOUT+1 RUN cycles, rsp_err=1, rsp_c=0.
//    Force m_done=1 on the TIMEOUT cycle -> rsp_err=0.
//  6 reset asserted mid-RUN -> next cycle: m_reset=1, no rsp_valid, gnt=0.
//    A new req0 then completes normally.

Source files
------------

// File: rtl/fp_mult_sched_pkg.sv
// Shared definitions for the fp_mult scheduler: FSM encoding, IEEE single field
// positions, response flow-bit layout and the early underflow predictor.
package fp_mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_RSP    = 2'd3
    } state_e;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;

    localparam int FLOW_OVF = 0;
    localparam int FLOW_UNF = 1;

    // fp_mult only reports overflow, so underflow is predicted from the biased
    // exponent sum of the operands before the operation starts.
    function automatic logic is_underflow(input logic [31:0] a, input logic [31:0] b);
        logic [8:0] exp_sum;
        exp_sum = {1'b0, a[FP_EXP_MSB:FP_EXP_LSB]} + {1'b0, b[FP_EXP_MSB:FP_EXP_LSB]};
        return exp_sum < 9'(FP_BIAS);
    endfunction

endpackage

// File: rtl/fp_mult_sched_if.sv
// Bundle of the requester side (req/operands/grant/response) and the fp_mult side
// of the scheduler. The slave modport is the scheduler's view.
interface fp_mult_sched_if #(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   a_in;
    logic [32*NREQ-1:0]   b_in;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_c;
    logic [1:0]           rsp_flow;
    logic                 rsp_err;

    logic [31:0]          m_a;
    logic [31:0]          m_b;
    logic                 m_reset;
    logic [31:0]          m_c;
    logic                 m_done;
    logic                 m_flow;

    modport slave (
        input  req, a_in, b_in, rsp_ready, m_c, m_done, m_flow,
        output gnt, rsp_valid, rsp_id, rsp_c, rsp_flow, rsp_err, m_a, m_b, m_reset
    );

    modport master (
        output req, a_in, b_in, rsp_ready, m_c, m_done, m_flow,
        input  gnt, rsp_valid, rsp_id, rsp_c, rsp_flow, rsp_err, m_a, m_b, m_reset
    );

endinterface

// File: rtl/fp_mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr+1 (mod NREQ)
// wins; returns both a one-hot grant and the encoded winner index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [IDW-1:0]  pos [NREQ];
    logic [NREQ-1:0] rot;

    // rot[k] is the request k+1 slots after the pointer, so lower k has priority.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum     = {1'b0, ptr_i} + (IDW+1)'(gi + 1);
            assign pos[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
            assign rot[gi] = req_i[pos[gi]];
        end
    endgenerate

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx_o = pos[k];
            end
        end
        gnt_o = '0;
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_sched.sv
// Round-robin scheduler time-sharing one externally instantiated fp_mult among NREQ
// requesters; restarts the multiplier per operation and returns results over valid/ready.
module fp_mult_sched
    import fp_mult_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 127
) (
    input  logic           clk,
    input  logic           reset,
    fp_mult_sched_if.slave bus
);

    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [31:0]     m_a_q;
    logic [31:0]     m_b_q;
    logic            m_reset_q;
    logic [IDW-1:0]  id_q;
    logic            uflow_q;
    logic [CNTW-1:0] cnt_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_c_q;
    logic [1:0]      rsp_flow_q;
    logic            rsp_err_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;
    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];
    logic [31:0]     a_sel_d;
    logic [31:0]     b_sel_d;
    logic            uflow_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.a_in[32*gi +: 32];
            assign b_arr[gi] = bus.b_in[32*gi +: 32];
        end
    endgenerate

    assign a_sel_d = a_arr[arb_idx];
    assign b_sel_d = b_arr[arb_idx];
    assign uflow_d = is_underflow(a_sel_d, b_sel_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            gnt_q       <= '0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            m_reset_q   <= 1'b1;
            id_q        <= '0;
            uflow_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_flow_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gnt_q     <= '0;
                    m_reset_q <= 1'b1;
                    if (arb_valid) begin
                        m_a_q   <= a_sel_d;
                        m_b_q   <= b_sel_d;
                        id_q    <= arb_idx;
                        gnt_q   <= arb_gnt;
                        ptr_q   <= arb_idx;
                        uflow_q <= uflow_d;
                        state_q <= ST_LAUNCH;
                    end
                end
                // fp_mult sits in reset with the latched operands for this cycle.
                ST_LAUNCH: begin
                    gnt_q     <= '0;
                    cnt_q     <= '0;
                    m_reset_q <= 1'b0;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.m_done) begin
                        rsp_c_q              <= bus.m_c;
                        rsp_flow_q[FLOW_UNF] <= uflow_q;
                        rsp_flow_q[FLOW_OVF] <= bus.m_flow & ~uflow_q;
                        rsp_err_q            <= 1'b0;
                        rsp_valid_q          <= 1'b1;
                        m_reset_q            <= 1'b1;
                        state_q              <= ST_RSP;
                    end else if (cnt_q == CNTW'(TIMEOUT)) begin
                        rsp_c_q     <= '0;
                        rsp_flow_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        m_reset_q   <= 1'b1;
                        state_q     <= ST_RSP;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_flow  = rsp_flow_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.m_a       = m_a_q;
    assign bus.m_b       = m_b_q;
    assign bus.m_reset   = m_reset_q;

endmodule

// File: tb/tb_fp_mult_sched.sv
// Bench for fp_mult_sched with a behavioural fp_mult stub (configurable latency, stuck
// or late done) and a reference model of round-robin order and expected responses.
module tb_fp_mult_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 127;

    logic clk;
    logic reset;

    fp_mult_sched_if #(.NREQ(NREQ)) bus ();

    fp_mult_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_w;
    int          stub_lat;
    int          stub_mode;
    logic [7:0]  stub_cnt = '0;
    logic [31:0] opa [NREQ];
    logic [31:0] opb [NREQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {overflow, C}: IEEE single multiply with truncation, flush to zero on over/underflow.
    function automatic logic [32:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, 32'h0};
        if (e <= 0) return 33'h0;
        return {1'b0, a[31] ^ b[31], 8'(e), m};
    endfunction

    // {underflow, overflow, C} the scheduler should report for a completed op.
    function automatic logic [33:0] ref_rsp(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        logic        unf;
        unf = (int'(a[30:23]) + int'(b[30:23])) < 127;
        r   = fpmul(a, b);
        return {unf, r[32] & ~unf, r[31:0]};
    endfunction

    function automatic int next_winner(input logic [NREQ-1:0] m, input int last);
        for (int d = 1; d <= NREQ; d++) begin
            if (m[(last + d) % NREQ]) return (last + d) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (bus.m_reset) stub_cnt <= '0;
        else if (stub_cnt != 8'hff) stub_cnt <= stub_cnt + 8'd1;
    end

    assign bus.m_done = !bus.m_reset &&
                        ((stub_mode == 0) ? (int'(stub_cnt) >= stub_lat) :
                         (stub_mode == 2) ? (int'(stub_cnt) == TIMEOUT) : 1'b0);
    assign {bus.m_flow, bus.m_c} = fpmul(bus.m_a, bus.m_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int i, input logic [31:0] a, input logic [31:0] b);
        opa[i] = a;
        opb[i] = b;
        bus.a_in[32*i +: 32] = a;
        bus.b_in[32*i +: 32] = b;
        bus.req[i] = 1'b1;
    endtask

    task automatic rand_fp(output logic [31:0] f);
        f = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endtask

    // Waits for a grant, drops that request, then waits for rsp_valid.
    task automatic serve(output logic [NREQ-1:0] g, output int lat, output int gcyc, output bit ok);
        ok = 1'b0; g = '0; lat = 0; gcyc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.gnt != '0) begin
                g = bus.gnt;
                break;
            end
        end
        if (g == '0) return;
        gcyc = 1;
        bus.req = bus.req & ~g;
        for (int i = 1; i < 400; i++) begin
            tick();
            if (bus.gnt != '0) gcyc++;
            if (bus.rsp_valid) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        $display("rsp id=%0d c=%h flow=%b err=%b", bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_c, bus.rsp_flow, bus.rsp_id, bus.m_a, bus.m_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got gnt=%b v=%b e=%b c=%h f=%b id=%0d ma=%h mb=%h, want all zero",
                     bus.gnt, bus.rsp_valid, bus.rsp_err, bus.rsp_c, bus.rsp_flow, bus.rsp_id, bus.m_a, bus.m_b);
        end
        n_cmp++;
        if (bus.m_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_m_reset: got %b want 1", bus.m_reset);
        end
        reset = 1'b0;
        last_w = NREQ - 1;
        tick();
        n_cmp++;
        if ({bus.m_reset, bus.gnt} !== {1'b1, {NREQ{1'b0}}}) begin
            n_bad++;
            $display("FAIL idle_after_reset: got m_reset=%b gnt=%b want 1/0000", bus.m_reset, bus.gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] g, one;
        logic [31:0]     a, b;
        logic [33:0]     e;
        int              lat, gcyc, w;
        bit              ok;
        stub_mode = 0;
        stub_lat  = 2;
        for (int i = 0; i < NREQ; i++) begin
            rand_fp(a);
            rand_fp(b);
            arm(i, a, b);
        end
        for (int k = 0; k < NREQ + 2; k++) begin
            if (k == NREQ) begin
                arm(0, opa[0], opb[0]);
                arm(3, opa[3], opb[3]);
            end
            w = (k < NREQ) ? k : ((k == NREQ) ? 0 : 3);
            one = '0;
            one[w] = 1'b1;
            e = ref_rsp(opa[w], opb[w]);
            serve(g, lat, gcyc, ok);
            n_cmp++;
            if (!ok || {g, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err} !== {one, 2'(w), e[31:0], e[33:32], 1'b0}) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got ok=%b gnt=%b id=%0d c=%h f=%b want gnt=%b id=%0d c=%h f=%b",
                         k, ok, g, bus.rsp_id, bus.rsp_c, bus.rsp_flow, one, w, e[31:0], e[33:32]);
            end
            last_w = w;
            if (ok) accept();
        end
    endtask

    task automatic test_basic();
        logic [NREQ-1:0] g;
        int              lat, gcyc;
        bit              ok;
        stub_mode = 0;
        stub_lat  = 4;
        arm(0, 32'h4000_0000, 32'h4040_0000);
        serve(g, lat, gcyc, ok);
        n_cmp++;
        if (!ok || {g, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err} !== {4'b0001, 2'd0, 32'h40C0_0000, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_2x3: got ok=%b gnt=%b id=%0d c=%h f=%b e=%b want 0001/0/40c00000/00/0",
                     ok, g, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err);
        end
        n_cmp++;
        if (gcyc !== 1) begin
            n_bad++;
            $display("FAIL basic_gnt_pulse: got %0d cycles want 1", gcyc);
        end
        n_cmp++;
        if (lat !== stub_lat + 2) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want %0d", lat, stub_lat + 2);
        end
        last_w = 0;
        if (ok) accept();
    endtask

    task automatic test_flow();
        logic [NREQ-1:0] g;
        logic [31:0]     ops [2];
        logic [1:0]      want_f [2];
        int              lat, gcyc;
        bit              ok;
        ops[0] = 32'h0080_0000; want_f[0] = 2'b10;
        ops[1] = 32'h7F00_0000; want_f[1] = 2'b01;
        stub_lat = 3;
        for (int k = 0; k < 2; k++) begin
            arm(0, ops[k], ops[k]);
            serve(g, lat, gcyc, ok);
            n_cmp++;
            if (!ok || {bus.rsp_flow, bus.rsp_c, bus.rsp_err} !== {want_f[k], 32'h0, 1'b0}) begin
                n_bad++;
                $display("FAIL flow[%0d]: got ok=%b f=%b c=%h e=%b want f=%b c=0 e=0",
                         k, ok, bus.rsp_flow, bus.rsp_c, bus.rsp_err, want_f[k]);
            end
            last_w = 0;
            if (ok) accept();
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] g;
        logic [31:0]     a, b;
        logic [33:0]     e;
        int              lat, gcyc;
        bit              ok, seen;
        stub_lat = 3;
        rand_fp(a);
        rand_fp(b);
        arm(0, a, b);
        e = ref_rsp(a, b);
        serve(g, lat, gcyc, ok);
        rand_fp(a);
        rand_fp(b);
        arm(1, a, b);
        n_cmp++;
        if (!ok || {bus.rsp_id, bus.rsp_c, bus.rsp_flow} !== {2'd0, e[31:0], e[33:32]}) begin
            n_bad++;
            $display("FAIL bp_first: got ok=%b id=%0d c=%h f=%b want 0/%h/%b", ok, bus.rsp_id, bus.rsp_c, bus.rsp_flow, e[31:0], e[33:32]);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err, bus.gnt} !==
                {1'b1, 2'd0, e[31:0], e[33:32], 1'b0, 4'b0000}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d c=%h f=%b gnt=%b want 1/0/%h/%b/0000",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.gnt, e[31:0], e[33:32]);
            end
        end
        accept();
        n_cmp++;
        if ({bus.rsp_valid, bus.gnt} !== 5'b0) begin
            n_bad++;
            $display("FAIL bp_accept: got v=%b gnt=%b want 0/0000", bus.rsp_valid, bus.gnt);
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_next_gnt: got %b want 0010", bus.gnt);
        end
        bus.req[1] = 1'b0;
        last_w = 1;
        e = ref_rsp(opa[1], opb[1]);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = bus.rsp_valid;
        end
        n_cmp++;
        if (!seen || {bus.rsp_id, bus.rsp_c} !== {2'd1, e[31:0]}) begin
            n_bad++;
            $display("FAIL bp_second: got seen=%b id=%0d c=%h want 1/1/%h", seen, bus.rsp_id, bus.rsp_c, e[31:0]);
        end
        if (seen) accept();
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] g;
        int              lat, gcyc;
        bit              ok;
        for (int k = 0; k < 2; k++) begin
            stub_mode = (k == 0) ? 1 : 2;
            arm(0, 32'h4000_0000, 32'h4040_0000);
            serve(g, lat, gcyc, ok);
            n_cmp++;
            if (!ok || lat !== TIMEOUT + 2) begin
                n_bad++;
                $display("FAIL timeout_lat[%0d]: got ok=%b lat=%0d want %0d", k, ok, lat, TIMEOUT + 2);
            end
            n_cmp++;
            if (k == 0 && {bus.rsp_err, bus.rsp_c, bus.rsp_flow} !== {1'b1, 32'h0, 2'b00}) begin
                n_bad++;
                $display("FAIL timeout_abort: got e=%b c=%h f=%b want 1/0/00", bus.rsp_err, bus.rsp_c, bus.rsp_flow);
            end else if (k == 1 && {bus.rsp_err, bus.rsp_c} !== {1'b0, 32'h40C0_0000}) begin
                n_bad++;
                $display("FAIL timeout_done_prio: got e=%b c=%h want 0/40c00000", bus.rsp_err, bus.rsp_c);
            end
            last_w = 0;
            if (ok) accept();
        end
        stub_mode = 0;
    endtask

    task automatic test_mid_reset();
        logic [NREQ-1:0] g;
        logic [33:0]     e;
        int              lat, gcyc;
        bit              ok, seen;
        stub_lat = 20;
        arm(0, 32'h3F80_0000, 32'h4000_0000);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = (bus.gnt != '0);
        end
        bus.req = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (!seen || {bus.m_reset, bus.rsp_valid, bus.gnt} !== {1'b1, 1'b0, 4'b0000}) begin
            n_bad++;
            $display("FAIL mid_reset: got seen=%b m_reset=%b v=%b gnt=%b want 1/1/0/0000", seen, bus.m_reset, bus.rsp_valid, bus.gnt);
        end
        last_w = NREQ - 1;
        repeat (25) tick();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_no_rsp: got v=%b want 0", bus.rsp_valid);
        end
        stub_lat = 5;
        arm(0, 32'h4000_0000, 32'h4040_0000);
        arm(1, 32'h3F80_0000, 32'h3F80_0000);
        for (int k = 0; k < 2; k++) begin
            e = ref_rsp(opa[k], opb[k]);
            serve(g, lat, gcyc, ok);
            n_cmp++;
            if (!ok || {g, bus.rsp_id, bus.rsp_c, bus.rsp_err} !== {4'(1 << k), 2'(k), e[31:0], 1'b0}) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: got ok=%b gnt=%b id=%0d c=%h want gnt=%b id=%0d c=%h",
                         k, ok, g, bus.rsp_id, bus.rsp_c, 4'(1 << k), k, e[31:0]);
            end
            last_w = k;
            if (ok) accept();
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g, one;
        logic [31:0]     a, b;
        logic [33:0]     e;
        int              lat, gcyc, w;
        bit              ok;
        stub_mode = 0;
        for (int t = 0; t < 40; t++) begin
            if (bus.req == '0) begin
                rand_fp(a);
                rand_fp(b);
                arm($urandom_range(0, NREQ - 1), a, b);
            end
            w = next_winner(bus.req, last_w);
            one = '0;
            one[w] = 1'b1;
            e = ref_rsp(opa[w], opb[w]);
            stub_lat = $urandom_range(0, 10);
            serve(g, lat, gcyc, ok);
            n_cmp++;
            if (!ok || {g, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err} !== {one, 2'(w), e[31:0], e[33:32], 1'b0}) begin
                n_bad++;
                $display("FAIL rand[%0d]: got ok=%b gnt=%b id=%0d c=%h f=%b e=%b want gnt=%b id=%0d c=%h f=%b e=0",
                         t, ok, g, bus.rsp_id, bus.rsp_c, bus.rsp_flow, bus.rsp_err, one, w, e[31:0], e[33:32]);
            end
            n_cmp++;
            if (lat !== stub_lat + 2) begin
                n_bad++;
                $display("FAIL rand_lat[%0d]: got %0d want %0d", t, lat, stub_lat + 2);
            end
            last_w = w;
            if (ok) accept();
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                    rand_fp(a);
                    rand_fp(b);
                    arm(i, a, b);
                end
            end
        end
        bus.req = '0;
    endtask

    initial begin
        reset         = 1'b1;
        stub_mode     = 0;
        stub_lat      = 2;
        last_w        = NREQ - 1;
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_basic();
        test_flow();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
